// File: rtl/decode_ctrl_cmp.sv
// decode_ctrl_cmp: MIPS D-stage instruction decoder, branch comparator and D/E boundary registers.
// Build option: define CMP_EXT_BRANCH_EN to add BLEZ/BGTZ/BLTZ/BGEZ (ibus widens to 14 bits).
module decode_ctrl_cmp #(
`ifdef CMP_EXT_BRANCH_EN
  parameter int NUM_I = 14,
`else
  parameter int NUM_I = 12,
`endif
  parameter logic [4:0] RA_IDX = 5'd31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [31:0]      instr,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      rt_val,
  output logic [NUM_I-1:0] ibus,
  output logic             ext_op,
  output logic [1:0]       reg_dst,
  output logic             is_branch,
  output logic             imm_jump,
  output logic             reg_jump,
  output logic             cmp_true,
  output logic             branch_jump,
  output logic [NUM_I-1:0] de_ibus,
  output logic [4:0]       de_wra,
  output logic [31:0]      de_ext
);

  localparam int I_ADDU = 0;
  localparam int I_SUBU = 1;
  localparam int I_ORI  = 2;
  localparam int I_LW   = 3;
  localparam int I_SW   = 4;
  localparam int I_BEQ  = 5;
  localparam int I_BNE  = 6;
  localparam int I_LUI  = 7;
  localparam int I_J    = 8;
  localparam int I_JAL  = 9;
  localparam int I_JR   = 10;
  localparam int I_NOP  = 11;
  localparam int I_BZ   = 12;
  localparam int I_RZ   = 13;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;
  localparam logic [5:0] F_ADDU    = 6'h21;
  localparam logic [5:0] F_SUBU    = 6'h23;
  localparam logic [5:0] F_JR      = 6'h08;

  logic [5:0]       op;
  logic [5:0]       funct;
  logic [4:0]       rt_f;
  logic [4:0]       rd_f;
  logic [4:0]       wra;
  logic [31:0]      ext_imm;
  logic [NUM_I-1:0] ibus_d, ibus_q;
  logic [4:0]       wra_d, wra_q;
  logic [31:0]      ext_d, ext_q;

  assign op    = instr[31:26];
  assign funct = instr[5:0];
  assign rt_f  = instr[20:16];
  assign rd_f  = instr[15:11];

  // One-hot decode; the all-zero word is NOP only, anything unknown leaves ibus clear.
  always_comb begin
    ibus = '0;
    if (instr == 32'h0000_0000) begin
      ibus[I_NOP] = 1'b1;
    end else begin
      case (op)
        OP_RTYPE: begin
          case (funct)
            F_ADDU:  ibus[I_ADDU] = 1'b1;
            F_SUBU:  ibus[I_SUBU] = 1'b1;
            F_JR:    ibus[I_JR]   = 1'b1;
            default: ibus         = '0;
          endcase
        end
        OP_ORI:  ibus[I_ORI] = 1'b1;
        OP_LW:   ibus[I_LW]  = 1'b1;
        OP_SW:   ibus[I_SW]  = 1'b1;
        OP_BEQ:  ibus[I_BEQ] = 1'b1;
        OP_BNE:  ibus[I_BNE] = 1'b1;
        OP_LUI:  ibus[I_LUI] = 1'b1;
        OP_J:    ibus[I_J]   = 1'b1;
        OP_JAL:  ibus[I_JAL] = 1'b1;
`ifdef CMP_EXT_BRANCH_EN
        OP_BLEZ, OP_BGTZ: ibus[I_BZ] = 1'b1;
        OP_REGIMM: begin
          if (rt_f == 5'd0 || rt_f == 5'd1) begin
            ibus[I_RZ] = 1'b1;
          end else begin
            ibus = '0;
          end
        end
`endif
        default: ibus = '0;
      endcase
    end
  end

  // Control fields derived from the one-hot bus.
  always_comb begin
    ext_op    = ibus[I_LW] | ibus[I_SW] | ibus[I_BEQ] | ibus[I_BNE];
    is_branch = ibus[I_BEQ] | ibus[I_BNE];
`ifdef CMP_EXT_BRANCH_EN
    ext_op    = ext_op | ibus[I_BZ] | ibus[I_RZ];
    is_branch = is_branch | ibus[I_BZ] | ibus[I_RZ];
`endif
    imm_jump  = ibus[I_J] | ibus[I_JAL];
    reg_jump  = ibus[I_JR];
    if (ibus[I_ADDU] || ibus[I_SUBU]) begin
      reg_dst = 2'b01;
    end else if (ibus[I_JAL]) begin
      reg_dst = 2'b10;
    end else begin
      reg_dst = 2'b00;
    end
  end

  // Branch comparator on forwarded operands; zero-compares are signed on rs_val alone.
  always_comb begin
    cmp_true = 1'b0;
    if (ibus[I_BEQ]) begin
      cmp_true = (rs_val == rt_val);
    end else if (ibus[I_BNE]) begin
      cmp_true = (rs_val != rt_val);
`ifdef CMP_EXT_BRANCH_EN
    end else if (ibus[I_BZ]) begin
      cmp_true = op[0] ? (!rs_val[31] && (rs_val != 32'h0000_0000))
                       : (rs_val[31] || (rs_val == 32'h0000_0000));
    end else if (ibus[I_RZ]) begin
      cmp_true = rt_f[0] ? !rs_val[31] : rs_val[31];
`endif
    end else begin
      cmp_true = 1'b0;
    end
  end

  assign branch_jump = is_branch & cmp_true;

  // Destination register and extended immediate for the D/E boundary.
  always_comb begin
    if (ibus[I_ORI] || ibus[I_LW] || ibus[I_LUI]) begin
      wra = rt_f;
    end else if (ibus[I_ADDU] || ibus[I_SUBU]) begin
      wra = rd_f;
    end else if (ibus[I_JAL]) begin
      wra = RA_IDX;
    end else begin
      wra = 5'd0;
    end
    ext_imm = ext_op ? {{16{instr[15]}}, instr[15:0]} : {16'h0000, instr[15:0]};
  end

  // A stall injects an all-zero bubble rather than holding the previous contents.
  always_comb begin
    if (stall) begin
      ibus_d = '0;
      wra_d  = 5'd0;
      ext_d  = 32'h0000_0000;
    end else begin
      ibus_d = ibus;
      wra_d  = wra;
      ext_d  = ext_imm;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ibus_q <= '0;
      wra_q  <= 5'd0;
      ext_q  <= 32'h0000_0000;
    end else begin
      ibus_q <= ibus_d;
      wra_q  <= wra_d;
      ext_q  <= ext_d;
    end
  end

  assign de_ibus = ibus_q;
  assign de_wra  = wra_q;
  assign de_ext  = ext_q;

endmodule

// File: tb/tb_decode_ctrl_cmp.sv
// tb_decode_ctrl_cmp: scoreboard bench for decode_ctrl_cmp with a table-driven reference model.
// Honours CMP_EXT_BRANCH_EN the same way as the design.
module tb_decode_ctrl_cmp;

`ifdef CMP_EXT_BRANCH_EN
  localparam int NUM_I = 14;
`else
  localparam int NUM_I = 12;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             stall = 1'b0;
  logic [31:0]      instr = 32'h0;
  logic [31:0]      rs_val = 32'h0;
  logic [31:0]      rt_val = 32'h0;
  logic [NUM_I-1:0] ibus;
  logic             ext_op, is_branch, imm_jump, reg_jump, cmp_true, branch_jump;
  logic [1:0]       reg_dst;
  logic [NUM_I-1:0] de_ibus;
  logic [4:0]       de_wra;
  logic [31:0]      de_ext;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] ins;
    logic [NUM_I-1:0] ibus;
    logic ext_op, is_branch, imm_jump, reg_jump, cmp_true, branch_jump;
    logic [1:0] reg_dst;
    logic [NUM_I-1:0] de_ibus;
    logic [4:0] de_wra;
    logic [31:0] de_ext;
  } exp_t;

  exp_t sb_q[$];

  decode_ctrl_cmp dut (
    .clk(clk), .reset(reset), .stall(stall), .instr(instr),
    .rs_val(rs_val), .rt_val(rt_val), .ibus(ibus), .ext_op(ext_op),
    .reg_dst(reg_dst), .is_branch(is_branch), .imm_jump(imm_jump),
    .reg_jump(reg_jump), .cmp_true(cmp_true), .branch_jump(branch_jump),
    .de_ibus(de_ibus), .de_wra(de_wra), .de_ext(de_ext)
  );

  always #5 clk = ~clk;

  // Mnemonic index from an encoding table: 0 ADDU .. 11 NOP, 12 BLEZ/BGTZ, 13 BLTZ/BGEZ, -1 unknown.
  function automatic int classify(logic [31:0] ins);
    logic [5:0] opc [14];
    logic [5:0] fnc [14];
    logic [5:0] op;
    logic [5:0] fn;
    opc = '{6'h00, 6'h00, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h0F, 6'h02, 6'h03, 6'h00, 6'h00, 6'h06, 6'h01};
    fnc = '{6'h21, 6'h23, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h00, 6'h00, 6'h00};
    op = ins[31:26];
    fn = ins[5:0];
    if (ins == 32'h0) return 11;
    for (int k = 0; k < NUM_I; k++) begin
      if (k == 11) continue;
      if (k == 12) begin
        if (op == 6'h06 || op == 6'h07) return 12;
      end else if (k == 13) begin
        if (op == 6'h01 && ins[20:17] == 4'h0) return 13;
      end else if (op == opc[k] && (op != 6'h00 || fn == fnc[k])) begin
        return k;
      end
    end
    return -1;
  endfunction

  function automatic exp_t model(logic [31:0] ins, logic [31:0] rs, logic [31:0] rt,
                                 logic rst, logic stl);
    exp_t e;
    int k;
    int signed srs;
    k = classify(ins);
    srs = $signed(rs);
    e.ins = ins;
    e.ibus = '0;
    if (k >= 0) e.ibus[k] = 1'b1;
    e.ext_op    = (k inside {3, 4, 5, 6, 12, 13});
    e.is_branch = (k inside {5, 6, 12, 13});
    e.imm_jump  = (k inside {8, 9});
    e.reg_jump  = (k == 10);
    e.reg_dst   = (k inside {0, 1}) ? 2'b01 : (k == 9) ? 2'b10 : 2'b00;
    case (k)
      5:  e.cmp_true = (rs == rt);
      6:  e.cmp_true = (rs != rt);
      12: e.cmp_true = (ins[31:26] == 6'h06) ? (srs <= 0) : (srs > 0);
      13: e.cmp_true = ins[16] ? (srs >= 0) : (srs < 0);
      default: e.cmp_true = 1'b0;
    endcase
    e.branch_jump = e.is_branch && e.cmp_true;
    if (rst || stl) begin
      e.de_ibus = '0;
      e.de_wra  = 5'd0;
      e.de_ext  = 32'h0;
    end else begin
      e.de_ibus = e.ibus;
      case (k)
        2, 3, 7: e.de_wra = ins[20:16];
        0, 1:    e.de_wra = ins[15:11];
        9:       e.de_wra = 5'd31;
        default: e.de_wra = 5'd0;
      endcase
      e.de_ext = e.ext_op ? 32'($signed(ins[15:0])) : 32'(ins[15:0]);
    end
    return e;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp, logic [31:0] ins);
    n_total++;
    if (act !== exp)
      $display("FAIL %s instr=%h t=%0t: got %h expected %h", nm, ins, $time, act, exp);
    else
      n_pass++;
  endtask

  task automatic issue(logic [31:0] ins, logic [31:0] rs, logic [31:0] rt, logic stl, logic rst);
    @(negedge clk);
    instr = ins; rs_val = rs; rt_val = rt; stall = stl; reset = rst;
    sb_q.push_back(model(ins, rs, rt, rst, stl));
  endtask

  // Monitor: after every active edge, compare whatever the stimulus queued for that edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("ibus",        32'(ibus),        32'(e.ibus),        e.ins);
        chk("ext_op",      32'(ext_op),      32'(e.ext_op),      e.ins);
        chk("reg_dst",     32'(reg_dst),     32'(e.reg_dst),     e.ins);
        chk("is_branch",   32'(is_branch),   32'(e.is_branch),   e.ins);
        chk("imm_jump",    32'(imm_jump),    32'(e.imm_jump),    e.ins);
        chk("reg_jump",    32'(reg_jump),    32'(e.reg_jump),    e.ins);
        chk("cmp_true",    32'(cmp_true),    32'(e.cmp_true),    e.ins);
        chk("branch_jump", 32'(branch_jump), 32'(e.branch_jump), e.ins);
        chk("de_ibus",     32'(de_ibus),     32'(e.de_ibus),     e.ins);
        chk("de_wra",      32'(de_wra),      32'(e.de_wra),      e.ins);
        chk("de_ext",      de_ext,           e.de_ext,           e.ins);
      end
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [13];
    logic [5:0] fns [4];
    logic [31:0] w;
    ops = '{6'h00, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h0F, 6'h02, 6'h03, 6'h06, 6'h07, 6'h01, 6'h00};
    fns = '{6'h21, 6'h23, 6'h08, 6'h00};
    w = $urandom;
    if ($urandom_range(0, 15) == 0) return 32'h0;
    w[31:26] = ops[$urandom_range(0, 12)];
    if ($urandom_range(0, 9) == 0) w[31:26] = 6'($urandom);
    if (w[31:26] == 6'h00) begin
      fns[3] = 6'($urandom);
      w[5:0] = fns[$urandom_range(0, 3)];
    end
    if (w[31:26] == 6'h01) w[20:16] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] a, b;
    issue(32'h0000_0000, 32'h0, 32'h0, 1'b0, 1'b1);
    issue(32'h0000_0000, 32'h0, 32'h0, 1'b0, 1'b1);
    issue(32'h1085_0003, 32'd5, 32'd5, 1'b0, 1'b0);
    issue(32'h1085_0003, 32'd5, 32'd6, 1'b0, 1'b0);
    issue(32'h0043_0821, 32'd0, 32'd0, 1'b0, 1'b0);
    issue(32'h3422_FFFF, 32'd0, 32'd0, 1'b0, 1'b0);
    issue(32'h8C22_FFFC, 32'd0, 32'd0, 1'b0, 1'b0);
    issue(32'h0C00_0010, 32'd0, 32'd0, 1'b0, 1'b0);
    issue(32'h03E0_0008, 32'd0, 32'd0, 1'b0, 1'b0);
    issue(32'h0043_0821, 32'd0, 32'd0, 1'b1, 1'b0);
    issue(32'h0043_0821, 32'd0, 32'd0, 1'b1, 1'b1);
    issue(32'h0043_0821, 32'd0, 32'd0, 1'b0, 1'b1);
    issue(32'h0043_0821, 32'd0, 32'd0, 1'b0, 1'b0);
    issue(32'h0401_0002, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    issue(32'h0401_0002, 32'h0, 32'd0, 1'b0, 1'b0);
    issue(32'h1800_0004, 32'h0, 32'd0, 1'b0, 1'b0);
    issue(32'h1C00_0004, 32'h0, 32'd0, 1'b0, 1'b0);
    issue(32'hFC00_0000, 32'h0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      a = rand_val();
      b = ($urandom_range(0, 2) == 0) ? a : rand_val();
      issue(rand_instr(), a, b, ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
    end
    @(negedge clk);
    @(negedge clk);
    n_total++;
    if (sb_q.size() != 0)
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    else
      n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
